// File: rtl/instr_dec_stage_pkg.sv
// Shared RV decode types: format tags, base opcodes and the decoded-entry record.
package rv_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    // Widest supported datapath; narrower builds leave the upper bits idle.
    localparam int XLEN_MAX = 64;

    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [5:0]          shamt;
        logic [XLEN_MAX-1:0] imm;
        fmt_e                fmt;
        logic                illegal;
    } dec_t;

endpackage

// File: rtl/instr_dec_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface instr_dec_stage_if
    import rv_pkg::*;
#(
    parameter int XLEN = 32
);
    localparam int SHW = $clog2(XLEN);

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [SHW-1:0]  out_shamt;
    logic [XLEN-1:0] out_imm;
    fmt_e            out_fmt;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_shamt, out_imm, out_fmt, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_shamt, out_imm, out_fmt, out_illegal
    );

endinterface

// File: rtl/instr_dec_stage_imm_gen.sv
// Immediate generator: picks the bit layout for the format and sign-extends to XLEN.
module imm_gen
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  fmt_e            fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;
    logic        unused_opc;

    assign unused_opc = ^instr[6:0];

    // Assemble the 32-bit immediate; every layout already carries its sign in bit 31.
    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    generate
        if (XLEN == 64) begin : g_ext64
            assign imm = {{32{imm32[31]}}, imm32};
        end else begin : g_ext32
            assign imm = imm32;
        end
    endgenerate

endmodule

// File: rtl/instr_dec_stage.sv
// Registered decode stage between fetch and execute, with optional skid entry.
module instr_dec_stage
    import rv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SKID_EN = 1
) (
    input logic               clk,
    input logic               rst_n,
    input logic               flush,
    instr_dec_stage_if.slave  bus
);

    localparam int SHW = $clog2(XLEN);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("instr_dec_stage: XLEN must be 32 or 64");
        end
    endgenerate

    logic [31:0]     instr;
    logic [6:0]      opc;
    logic [2:0]      f3;
    fmt_e            dec_fmt;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;
    dec_t            dec_d;
    dec_t            main_q;
    dec_t            skid_q;
    logic            out_valid_q;
    logic            skid_valid_q;
    logic            in_ready;
    logic            in_fire;
    logic            main_free;

    assign instr = bus.in_instr;
    assign opc   = instr[6:0];
    assign f3    = instr[14:12];

    // Classify the opcode; anything unrecognised is flagged and treated as I-format.
    always_comb begin
        dec_fmt     = FMT_I;
        dec_illegal = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC: dec_fmt = FMT_U;
            OPC_JAL:            dec_fmt = FMT_J;
            OPC_BRANCH:         dec_fmt = FMT_B;
            OPC_STORE:          dec_fmt = FMT_S;
            OPC_OP:             dec_fmt = FMT_R;
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_MISCMEM, OPC_SYSTEM: dec_fmt = FMT_I;
            OPC_OPIMM32: begin
                if (XLEN != 64) dec_illegal = 1'b1;
            end
            OPC_OP32: begin
                if (XLEN == 64) dec_fmt = FMT_R;
                else            dec_illegal = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
        if (instr[1:0] != 2'b11 || instr == 32'd0) dec_illegal = 1'b1;
        if (XLEN == 32 && opc == OPC_OPIMM && (f3 == 3'b001 || f3 == 3'b101) && instr[25])
            dec_illegal = 1'b1;
        if (dec_illegal) dec_fmt = FMT_I;
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (instr),
        .fmt   (dec_fmt),
        .imm   (dec_imm)
    );

    // Pack the decoded fields into the entry record that the buffers hold.
    always_comb begin
        dec_d         = '0;
        dec_d.pc      = XLEN_MAX'(bus.in_pc);
        dec_d.rd      = instr[11:7];
        dec_d.rs1     = instr[19:15];
        dec_d.rs2     = instr[24:20];
        dec_d.funct3  = instr[14:12];
        dec_d.funct7  = instr[31:25];
        dec_d.shamt   = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};
        dec_d.imm     = XLEN_MAX'(dec_imm);
        dec_d.fmt     = dec_fmt;
        dec_d.illegal = dec_illegal;
    end

    assign in_ready  = (SKID_EN != 0) ? !skid_valid_q : (!out_valid_q || bus.out_ready);
    assign main_free = !out_valid_q || bus.out_ready;
    assign in_fire   = bus.in_valid && in_ready && !flush;

    // Main/skid buffering: skid drains into main first so order stays FIFO; flush wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                main_q       <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (in_fire) begin
                main_q      <= dec_d;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (in_fire) begin
            skid_q       <= dec_d;
            skid_valid_q <= 1'b1;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_pc      = main_q.pc[XLEN-1:0];
    assign bus.out_rd      = main_q.rd;
    assign bus.out_rs1     = main_q.rs1;
    assign bus.out_rs2     = main_q.rs2;
    assign bus.out_funct3  = main_q.funct3;
    assign bus.out_funct7  = main_q.funct7;
    assign bus.out_shamt   = main_q.shamt[SHW-1:0];
    assign bus.out_imm     = main_q.imm[XLEN-1:0];
    assign bus.out_fmt     = main_q.fmt;
    assign bus.out_illegal = main_q.illegal;

    generate
        if (XLEN < XLEN_MAX) begin : g_narrow
            logic unused_hi;
            assign unused_hi = ^{main_q.pc[XLEN_MAX-1:XLEN], main_q.imm[XLEN_MAX-1:XLEN],
                                 main_q.shamt[5]};
        end
    endgenerate

endmodule

// File: tb/tb_instr_dec_stage.sv
// Bench for instr_dec_stage: directed cases plus random traffic against a queue model.
module tb_instr_dec_stage;
    import rv_pkg::*;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] imm;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [5:0]  shamt;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    instr_dec_stage_if #(.XLEN(32)) bus32 ();
    instr_dec_stage_if #(.XLEN(64)) bus64 ();

    instr_dec_stage #(.XLEN(32), .SKID_EN(1)) dut32 (
        .clk (clk), .rst_n (rst_n), .flush (flush), .bus (bus32.slave)
    );
    instr_dec_stage #(.XLEN(64), .SKID_EN(0)) dut64 (
        .clk (clk), .rst_n (rst_n), .flush (flush), .bus (bus64.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decode written from the encoding rules using signed arithmetic.
    function automatic exp_t refDecode(input int xlen, input logic [31:0] instr, input logic [63:0] pc);
        exp_t   e;
        longint s;
        logic [6:0] opc;
        logic   bad;
        opc = instr[6:0];
        bad = 1'b0;
        e.fmt = 3'd1;
        case (opc)
            7'h37, 7'h17: e.fmt = 3'd4;
            7'h6F:        e.fmt = 3'd5;
            7'h63:        e.fmt = 3'd3;
            7'h23:        e.fmt = 3'd2;
            7'h33:        e.fmt = 3'd0;
            7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: e.fmt = 3'd1;
            7'h1B:        bad = (xlen != 64);
            7'h3B:        begin if (xlen == 64) e.fmt = 3'd0; else bad = 1'b1; end
            default:      bad = 1'b1;
        endcase
        if (instr[1:0] != 2'b11 || instr == 32'd0) bad = 1'b1;
        if (xlen == 32 && opc == 7'h13 && (instr[14:12] == 3'd1 || instr[14:12] == 3'd5) && instr[25])
            bad = 1'b1;
        if (bad) e.fmt = 3'd1;
        e.ill = bad;
        s = longint'($signed(instr));
        case (e.fmt)
            3'd1: s = s >>> 20;
            3'd2: s = ((s >>> 25) <<< 5) | longint'(instr[11:7]);
            3'd3: s = ((s >>> 31) <<< 12) | (longint'(instr[7]) << 11)
                      | (longint'(instr[30:25]) << 5) | (longint'(instr[11:8]) << 1);
            3'd4: s = s & -64'sd4096;
            3'd5: s = ((s >>> 31) <<< 20) | (longint'(instr[19:12]) << 12)
                      | (longint'(instr[20]) << 11) | (longint'(instr[30:21]) << 1);
            default: s = 0;
        endcase
        e.imm   = (xlen == 32) ? (64'(s) & 64'hFFFF_FFFF) : 64'(s);
        e.pc    = (xlen == 32) ? (pc & 64'hFFFF_FFFF) : pc;
        e.rd    = instr[11:7];
        e.rs1   = instr[19:15];
        e.rs2   = instr[24:20];
        e.f3    = instr[14:12];
        e.f7    = instr[31:25];
        e.shamt = (xlen == 64) ? instr[25:20] : {1'b0, instr[24:20]};
        return e;
    endfunction

    // One cycle: drive at negedge, check against the model, then advance the model.
    task automatic applyStimulus(input bit sel64, input bit inV, input logic [31:0] instr,
                                 input logic [63:0] pc, input bit outR, input bit fl);
        logic ov, ir, expReady;
        exp_t o;
        @(negedge clk);
        flush = fl;
        if (!sel64) begin
            bus32.in_valid = inV; bus32.in_instr = instr; bus32.in_pc = pc[31:0]; bus32.out_ready = outR;
        end else begin
            bus64.in_valid = inV; bus64.in_instr = instr; bus64.in_pc = pc; bus64.out_ready = outR;
        end
        #1;
        if (!sel64) begin
            ov = bus32.out_valid; ir = bus32.in_ready;
            o.pc = 64'(bus32.out_pc); o.imm = 64'(bus32.out_imm); o.shamt = 6'(bus32.out_shamt);
            o.rd = bus32.out_rd; o.rs1 = bus32.out_rs1; o.rs2 = bus32.out_rs2;
            o.f3 = bus32.out_funct3; o.f7 = bus32.out_funct7; o.fmt = bus32.out_fmt; o.ill = bus32.out_illegal;
            expReady = (q.size() < 2);
        end else begin
            ov = bus64.out_valid; ir = bus64.in_ready;
            o.pc = bus64.out_pc; o.imm = bus64.out_imm; o.shamt = bus64.out_shamt;
            o.rd = bus64.out_rd; o.rs1 = bus64.out_rs1; o.rs2 = bus64.out_rs2;
            o.f3 = bus64.out_funct3; o.f7 = bus64.out_funct7; o.fmt = bus64.out_fmt; o.ill = bus64.out_illegal;
            expReady = (q.size() == 0) || outR;
        end
        checkOutput("out_valid", 64'(ov), 64'(q.size() != 0));
        checkOutput("in_ready", 64'(ir), 64'(expReady));
        if (ov && q.size() != 0) begin
            checkOutput("pc", o.pc, q[0].pc);
            checkOutput("imm", o.imm, q[0].imm);
            checkOutput("fields", {o.rd, o.rs1, o.rs2, o.f3, o.f7, o.shamt, o.fmt, o.ill},
                        {q[0].rd, q[0].rs1, q[0].rs2, q[0].f3, q[0].f7, q[0].shamt, q[0].fmt, q[0].ill});
        end
        if (fl) begin
            q.delete();
        end else begin
            if (ov && outR && q.size() != 0) void'(q.pop_front());
            if (inV && expReady) q.push_back(refDecode(sel64 ? 64 : 32, instr, pc));
        end
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] instr;
        logic [6:0]  opcs [13];
        int r;
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h1B, 7'h3B, 7'h0F, 7'h73};
        instr = $urandom;
        r = int'($urandom_range(0, 15));
        if (r < 11) begin
            instr[6:0] = opcs[$urandom_range(0, 12)];
        end else if (r == 11) begin
            instr = 32'd0;
        end else if (r == 12) begin
            instr[6:0]   = 7'h13;
            instr[14:12] = ($urandom_range(0, 1) == 1) ? 3'd1 : 3'd5;
            instr[25]    = 1'b1;
        end
        return instr;
    endfunction

    initial begin
        bus32.in_valid = 1'b0; bus32.in_instr = '0; bus32.in_pc = '0; bus32.out_ready = 1'b0;
        bus64.in_valid = 1'b0; bus64.in_instr = '0; bus64.in_pc = '0; bus64.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_out_valid", 64'(bus32.out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(bus32.in_ready), 64'd1);
        checkOutput("rst_fmt", 64'(bus32.out_fmt), 64'd0);
        checkOutput("rst_imm", 64'(bus32.out_imm), 64'd0);

        // ADDI x1,x2,-1
        applyStimulus(0, 1, 32'hFFF10093, 64'h100, 1, 0);
        applyStimulus(0, 0, 32'h0, 64'h0, 1, 0);
        checkOutput("addi_valid", 64'(bus32.out_valid), 64'd1);
        checkOutput("addi_rd", 64'(bus32.out_rd), 64'd1);
        checkOutput("addi_rs1", 64'(bus32.out_rs1), 64'd2);
        checkOutput("addi_fmt", 64'(bus32.out_fmt), 64'd1);
        checkOutput("addi_imm", 64'(bus32.out_imm), 64'hFFFF_FFFF);
        checkOutput("addi_ill", 64'(bus32.out_illegal), 64'd0);
        // BEQ x0,x0,-4
        applyStimulus(0, 1, 32'hFE000EE3, 64'h104, 1, 0);
        applyStimulus(0, 0, 32'h0, 64'h0, 1, 0);
        checkOutput("beq_fmt", 64'(bus32.out_fmt), 64'd3);
        checkOutput("beq_imm", 64'(bus32.out_imm), 64'hFFFF_FFFC);
        // LUI x5,0x12345
        applyStimulus(0, 1, 32'h123452B7, 64'h108, 1, 0);
        applyStimulus(0, 0, 32'h0, 64'h0, 1, 0);
        checkOutput("lui_fmt", 64'(bus32.out_fmt), 64'd4);
        checkOutput("lui_rd", 64'(bus32.out_rd), 64'd5);
        checkOutput("lui_imm", 64'(bus32.out_imm), 64'h1234_5000);
        // all-zero word and 32-bit shift overflow
        applyStimulus(0, 1, 32'h00000000, 64'h10C, 1, 0);
        applyStimulus(0, 0, 32'h0, 64'h0, 1, 0);
        checkOutput("zero_ill", 64'(bus32.out_illegal), 64'd1);
        applyStimulus(0, 1, 32'h02009093, 64'h110, 1, 0);
        applyStimulus(0, 0, 32'h0, 64'h0, 1, 0);
        checkOutput("slli32_ill", 64'(bus32.out_illegal), 64'd1);
        // 64-bit build
        applyStimulus(1, 1, 32'h800002B7, 64'h200, 1, 0);
        applyStimulus(1, 0, 32'h0, 64'h0, 1, 0);
        checkOutput("lui64_imm", bus64.out_imm, 64'hFFFF_FFFF_8000_0000);
        applyStimulus(1, 1, 32'h02009093, 64'h204, 1, 0);
        applyStimulus(1, 0, 32'h0, 64'h0, 1, 0);
        checkOutput("slli64_ill", 64'(bus64.out_illegal), 64'd0);
        checkOutput("slli64_shamt", 64'(bus64.out_shamt), 64'd32);

        // Back-to-back A,B,C into a stalled stage
        applyStimulus(0, 1, 32'h00100093, 64'hA00, 0, 0);
        applyStimulus(0, 1, 32'h00200113, 64'hB00, 0, 0);
        applyStimulus(0, 1, 32'h00300193, 64'hC00, 0, 0);
        checkOutput("skid_full_ready", 64'(bus32.in_ready), 64'd0);
        checkOutput("skid_head_a", 64'(bus32.out_pc), 64'hA00);
        applyStimulus(0, 1, 32'h00300193, 64'hC00, 1, 0);
        checkOutput("order_a", 64'(bus32.out_pc), 64'hA00);
        applyStimulus(0, 1, 32'h00300193, 64'hC00, 1, 0);
        checkOutput("order_b", 64'(bus32.out_pc), 64'hB00);
        applyStimulus(0, 0, 32'h0, 64'h0, 1, 0);
        checkOutput("order_c", 64'(bus32.out_pc), 64'hC00);
        applyStimulus(0, 0, 32'h0, 64'h0, 1, 0);
        checkOutput("drained", 64'(bus32.out_valid), 64'd0);

        // Flush with both entries full, then with an empty stage
        applyStimulus(0, 1, 32'h00100093, 64'hA10, 0, 0);
        applyStimulus(0, 1, 32'h00200113, 64'hB10, 0, 0);
        applyStimulus(0, 1, 32'h00400213, 64'hD10, 0, 1);
        applyStimulus(0, 1, 32'h00500293, 64'hE10, 0, 1);
        applyStimulus(0, 0, 32'h0, 64'h0, 0, 0);
        checkOutput("flush_valid", 64'(bus32.out_valid), 64'd0);
        checkOutput("flush_ready", 64'(bus32.in_ready), 64'd1);
        applyStimulus(0, 0, 32'h0, 64'h0, 1, 0);

        // Asynchronous reset with both entries held
        applyStimulus(0, 1, 32'h00100093, 64'hA20, 0, 0);
        applyStimulus(0, 1, 32'h00200113, 64'hB20, 0, 0);
        @(negedge clk);
        bus32.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 64'(bus32.out_valid), 64'd0);
        checkOutput("async_rst_ready", 64'(bus32.in_ready), 64'd1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 1, 32'h00600313, 64'hF20, 1, 0);
        applyStimulus(0, 0, 32'h0, 64'h0, 1, 0);
        checkOutput("post_rst_valid", 64'(bus32.out_valid), 64'd1);
        checkOutput("post_rst_pc", 64'(bus32.out_pc), 64'hF20);
        applyStimulus(0, 0, 32'h0, 64'h0, 1, 0);

        // Random traffic, 32-bit skid build then 64-bit pass-through build
        for (int sel = 0; sel < 2; sel++) begin
            for (int i = 0; i < 600; i++) begin
                applyStimulus(sel[0], $urandom_range(0, 3) != 0, randInstr(), {$urandom, $urandom},
                              $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
            end
            applyStimulus(sel[0], 0, 32'h0, 64'h0, 0, 1);
            applyStimulus(sel[0], 0, 32'h0, 64'h0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
